// File: rtl/next_piece_queue_pkg.sv
// Shared piece definitions for the tetris datapath.
// Piece IDs 0..6 are valid; 7 is the generator's "no piece" code.
package tetris_pkg;

    localparam int PIECE_ID_W = 3;
    localparam int NUM_PIECES = 7;

    typedef enum logic [PIECE_ID_W-1:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_e;

    localparam logic [PIECE_ID_W-1:0] PIECE_INVALID = 3'd7;

endpackage

// File: rtl/next_piece_queue_if.sv
// Bundle between the piece queue, the generator and game control.
// Hold-slot signals exist only when HOLD_SLOT_EN is defined.
interface next_piece_queue_if #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            gen_req;
    logic [ID_W-1:0] gen_id;
    logic            spawn_req;
    logic            spawn_valid;
    logic [ID_W-1:0] spawn_id;
    logic [ID_W-1:0] preview_id;
    logic            preview_valid;
    logic [CW-1:0]   count;
`ifdef HOLD_SLOT_EN
    logic            hold_req;
    logic [ID_W-1:0] hold_in_id;
    logic [ID_W-1:0] hold_id;
    logic            hold_valid;
    logic [ID_W-1:0] hold_out_id;

    modport slave (
        input  gen_id, spawn_req, hold_req, hold_in_id,
        output gen_req, spawn_valid, spawn_id, preview_id,
        output preview_valid, count,
        output hold_id, hold_valid, hold_out_id
    );
    modport master (
        output gen_id, spawn_req, hold_req, hold_in_id,
        input  gen_req, spawn_valid, spawn_id, preview_id,
        input  preview_valid, count,
        input  hold_id, hold_valid, hold_out_id
    );
`else
    modport slave (
        input  gen_id, spawn_req,
        output gen_req, spawn_valid, spawn_id, preview_id,
        output preview_valid, count
    );
    modport master (
        output gen_id, spawn_req,
        input  gen_req, spawn_valid, spawn_id, preview_id,
        input  preview_valid, count
    );
`endif

endinterface

// File: rtl/next_piece_queue_fifo.sv
// piece_fifo: small circular buffer of piece IDs with
// combinational head and head+1 reads for the preview panel.
module piece_fifo #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 3,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr,
    input  logic [ID_W-1:0] i_wr_id,
    input  logic            i_rd,
    output logic [ID_W-1:0] o_head,
    output logic [ID_W-1:0] o_next,
    output logic [CW-1:0]   o_count
);
    logic [ID_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_rptr_nxt;
    logic            w_rd;
    logic            w_wr;

    assign w_rd       = i_rd && (r_count != '0);
    assign w_wr       = i_wr && ((r_count != CW'(DEPTH)) || w_rd);
    assign w_rptr_nxt = r_rptr + PW'(1);

    assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign o_next  = (r_count >= CW'(2)) ? r_mem[w_rptr_nxt] : '0;
    assign o_count = r_count;

    // Storage write; contents need no reset since reads are gated by count.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wptr] <= i_wr_id;
        end
    end

    // Pointer and occupancy update; pointers wrap modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PW'(1);
            if (w_rd) r_rptr <= w_rptr_nxt;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/next_piece_queue.sv
// Prefetches piece IDs from the generator into a FIFO and serves spawns.
// Optional hold slot enabled by defining HOLD_SLOT_EN.
module next_piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = PIECE_ID_W,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    next_piece_queue_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2
    } state_e;

    state_e          r_state;
    logic            r_gen_req;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_post;
    logic [ID_W-1:0] w_head;
    logic [ID_W-1:0] w_next;
    logic [ID_W-1:0] w_clean_id;
    logic            w_valid;
    logic            w_pop;
    logic            w_wr;

    assign w_valid    = (w_count != '0);
    assign w_wr       = (r_state == S_CAP);
    assign w_clean_id = (bus.gen_id == ID_W'(PIECE_INVALID)) ? '0 : bus.gen_id;
    assign w_post     = {1'b0, w_count} + (CW+1)'(1) - (CW+1)'(w_pop);

`ifdef HOLD_SLOT_EN
    logic            r_hold_valid;
    logic            r_hold_lock;
    logic [ID_W-1:0] r_hold_id;
    logic            w_hold_acc;
    logic            w_spawn_pop;

    assign w_hold_acc  = bus.hold_req && !r_hold_lock
                       && (r_hold_valid || w_valid);
    assign w_spawn_pop = !w_hold_acc && bus.spawn_req && w_valid;
    assign w_pop       = w_spawn_pop || (w_hold_acc && !r_hold_valid);

    assign bus.hold_id     = r_hold_id;
    assign bus.hold_valid  = r_hold_valid;
    assign bus.hold_out_id = r_hold_valid ? r_hold_id : w_head;

    // Hold slot: one swap per spawn, lock released by the next real spawn.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_valid <= 1'b0;
            r_hold_lock  <= 1'b0;
            r_hold_id    <= '0;
        end else if (w_hold_acc) begin
            r_hold_valid <= 1'b1;
            r_hold_lock  <= 1'b1;
            r_hold_id    <= bus.hold_in_id;
        end else if (w_spawn_pop) begin
            r_hold_lock  <= 1'b0;
        end
    end
`else
    assign w_pop = bus.spawn_req && w_valid;
`endif

    piece_fifo #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_wr    (w_wr),
        .i_wr_id (w_clean_id),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (w_count)
    );

    assign bus.gen_req       = r_gen_req;
    assign bus.spawn_valid   = w_valid;
    assign bus.spawn_id      = w_head;
    assign bus.preview_id    = w_next;
    assign bus.preview_valid = (w_count >= CW'(2));
    assign bus.count         = w_count;

    // Fetch FSM: one outstanding request, capture the cycle after it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_gen_req <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_count < CW'(DEPTH)) begin
                        r_state   <= S_REQ;
                        r_gen_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_state   <= S_CAP;
                    r_gen_req <= 1'b0;
                end
                S_CAP: begin
                    if (w_post < (CW+1)'(DEPTH)) begin
                        r_state   <= S_REQ;
                        r_gen_req <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_gen_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_gen_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_next_piece_queue.sv
// Bench for next_piece_queue: directed fill table, corner sequences,
// and random spawns against a queue-based reference model.
module tb_next_piece_queue;
    import tetris_pkg::*;

    localparam int DEPTH = 4;
    localparam int ID_W  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    next_piece_queue_if #(.DEPTH(DEPTH), .ID_W(ID_W)) ifc();

    next_piece_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.slave)
    );

    // Generator model: advances on every edge where gen_req is high.
    int   seq [7] = '{3, 6, 5, 1, 2, 0, 4};
    int   pos = 6;
    logic force7 = 1'b0;
    always @(posedge CLK) if (ifc.gen_req === 1'b1) pos <= (pos + 1) % 7;
    assign ifc.gen_id = force7 ? 3'd7 : 3'(seq[pos]);

    int passed = 0;
    int total  = 0;

    int q[$];
    bit pend = 0;
    int idle_run = 0;

    typedef struct {
        bit sp;
        int gr;
        int cnt;
        int sid;
        int pid;
    } vec_t;
    vec_t tv[16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_check();
        int n;
        n = q.size();
        chk("count", int'(ifc.count), n);
        chk("spawn_valid", int'(ifc.spawn_valid), int'(n > 0));
        if (n > 0) chk("spawn_id", int'(ifc.spawn_id), q[0]);
        chk("preview_valid", int'(ifc.preview_valid), int'(n >= 2));
        chk("preview_id", int'(ifc.preview_id), (n >= 2) ? q[1] : 0);
        if (ifc.gen_req) chk("req_legal", int'(!pend && n < DEPTH), 1);
        if (RST) idle_run = 0;
        else if (!ifc.gen_req && !pend && n < DEPTH) idle_run++;
        else idle_run = 0;
        chk("fetch_stall", int'(idle_run < 2), 1);
    endtask

    // Compare now, drive inputs for the next edge, advance the model.
    task automatic step(input bit sp, input bit rst);
        int g;
        model_check();
        ifc.spawn_req = sp;
        RST = rst;
        g = force7 ? 7 : seq[pos];
        if (rst) begin
            q.delete();
            pend = 0;
        end else begin
            if (sp && q.size() > 0) void'(q.pop_front());
            if (pend) q.push_back((g == 7) ? 0 : g);
            pend = ifc.gen_req;
        end
        @(negedge CLK);
    endtask

    initial begin
        int seen0;
        int n;
        bit got;
`ifdef HOLD_SLOT_EN
        int h1;
        int h2;
        ifc.hold_req   = 1'b0;
        ifc.hold_in_id = '0;
`endif
        ifc.spawn_req = 1'b0;

        tv[0]  = '{0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0, 0};
        tv[3]  = '{0, 1, 1, 3, 0};
        tv[4]  = '{0, 0, 1, 3, 0};
        tv[5]  = '{0, 1, 2, 3, 6};
        tv[6]  = '{0, 0, 2, 3, 6};
        tv[7]  = '{0, 1, 3, 3, 6};
        tv[8]  = '{0, 0, 3, 3, 6};
        tv[9]  = '{0, 0, 4, 3, 6};
        tv[10] = '{1, 0, 4, 3, 6};
        tv[11] = '{0, 0, 3, 6, 5};
        tv[12] = '{0, 1, 3, 6, 5};
        tv[13] = '{0, 0, 3, 6, 5};
        tv[14] = '{0, 0, 4, 6, 5};
        tv[15] = '{0, 0, 4, 6, 5};

        repeat (2) @(negedge CLK);

        // Fill after reset and one spawn from full.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tv%0d_gen_req", i), int'(ifc.gen_req), tv[i].gr);
            chk($sformatf("tv%0d_count", i), int'(ifc.count), tv[i].cnt);
            if (tv[i].cnt != 0 || i == 0)
                chk($sformatf("tv%0d_spawn_id", i), int'(ifc.spawn_id), tv[i].sid);
            chk($sformatf("tv%0d_preview_id", i), int'(ifc.preview_id), tv[i].pid);
            step(tv[i].sp, 1'b0);
        end

        // Spawn held for 12 cycles from full drains the queue.
        seen0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (ifc.count == '0) seen0 = 1;
            step(1'b1, 1'b0);
        end
        chk("drain_reached_zero", seen0, 1);

        // Invalid generator output is stored as piece 0.
        force7 = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        force7 = 1'b0;
        n = q.size();
        for (int i = 0; i < n - 1; i++) step(1'b1, 1'b0);
        chk("sanitized_tail", int'(ifc.spawn_id), 0);

        // Reset landing in S_CAP discards the capture.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (ifc.gen_req) got = 1;
            else step(1'b0, 1'b0);
        end
        chk("saw_req_before_cap", int'(got), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("rst_cap_count", int'(ifc.count), 0);
        chk("rst_cap_gen_req", int'(ifc.gen_req), 0);
        chk("rst_cap_spawn_valid", int'(ifc.spawn_valid), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("refill_after_reset", int'(ifc.count), DEPTH);

        // Random spawns, invalid IDs and resets against the model.
        for (int i = 0; i < 400; i++) begin
            force7 = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        end
        force7 = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

`ifdef HOLD_SLOT_EN
        // Hold slot sequence; the model is not used beyond this point.
        h1 = q[1];
        h2 = q[2];
        ifc.hold_req   = 1'b1;
        ifc.hold_in_id = 3'd4;
        #1;
        chk("hold1_out_id", int'(ifc.hold_out_id), q[0]);
        @(negedge CLK);
        ifc.hold_req = 1'b0;
        chk("hold1_hold_id", int'(ifc.hold_id), 4);
        chk("hold1_valid", int'(ifc.hold_valid), 1);
        chk("hold1_popped", int'(ifc.count), DEPTH - 1);
        chk("hold1_head", int'(ifc.spawn_id), h1);
        ifc.hold_req   = 1'b1;
        ifc.hold_in_id = 3'd2;
        @(negedge CLK);
        ifc.hold_req = 1'b0;
        chk("hold_locked_id", int'(ifc.hold_id), 4);
        chk("hold_locked_head", int'(ifc.spawn_id), h1);
        ifc.spawn_req = 1'b1;
        @(negedge CLK);
        ifc.spawn_req = 1'b0;
        chk("spawn_after_hold", int'(ifc.spawn_id), h2);
        ifc.hold_req   = 1'b1;
        ifc.hold_in_id = 3'd1;
        #1;
        chk("hold2_out_id", int'(ifc.hold_out_id), 4);
        @(negedge CLK);
        ifc.hold_req = 1'b0;
        chk("hold2_hold_id", int'(ifc.hold_id), 1);
        chk("hold2_no_pop", int'(ifc.spawn_id), h2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
